// File: rtl/formula_arg_packer.sv
// formula_arg_packer
//   Gathers three serial 32-bit operand words (a, b, c) into one argument
//   triple for the formula pipe. It issues at most one triple per three
//   cycles, and a credit counter limits the number of triples in flight.
//
// Ports
//   clk       single clock; all state updates on its rising edge
//   rst       asynchronous, active-high reset
//   clr       synchronous restart of the gather FSM; drops any partial triple
//   in_vld    in_data is valid
//   in_data   serial operand word, sent in the order a, b, c
//   in_rdy    the block accepts in_data this cycle (combinational)
//   cred_ret  downstream freed one result slot
//   arg_vld   one-cycle pulse; a/b/c hold a complete triple
//   a, b, c   packed operands; these change only when a word is accepted
//   credits   current free credit count
//   cred_err  sticky error: a credit was returned while the counter was full
module formula_arg_packer #(
    parameter int CREDITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    output logic        in_rdy,
    input  logic        cred_ret,
    output logic        arg_vld,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [7:0]  credits,
    output logic        cred_err
);

    localparam logic [7:0] CRED_MAX = 8'(CREDITS);

    typedef enum logic [1:0] {S_A, S_B, S_C} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q, c_q;
    logic        vld_q;
    logic [7:0]  cred_q, cred_d;
    logic        err_q, err_d;
    logic        accept;
    logic        issue;

    // The c word is held off while no credit is free. clr blocks every
    // accept, so an issue can never coincide with a restart.
    always_comb begin
        in_rdy = !clr && ((state_q != S_C) || (cred_q != 8'd0));
        accept = in_vld && in_rdy;
        issue  = accept && (state_q == S_C);
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_A;
        end else if (accept) begin
            case (state_q)
                S_A:     state_d = S_B;
                S_B:     state_d = S_C;
                S_C:     state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    // Issuing a triple and returning a credit in the same cycle cancel out.
    // A return while the counter is already full is dropped and latched as
    // an error.
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (issue && !cred_ret) begin
            cred_d = cred_q - 8'd1;
        end else if (cred_ret && !issue) begin
            if (cred_q == CRED_MAX) err_d  = 1'b1;
            else                    cred_d = cred_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            vld_q   <= 1'b0;
            cred_q  <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
            // The pulse follows the issue edge. clr cannot cancel a pulse
            // that is already under way.
            vld_q   <= issue;
            if (accept && state_q == S_A) a_q <= in_data;
            if (accept && state_q == S_B) b_q <= in_data;
            if (accept && state_q == S_C) c_q <= in_data;
        end
    end

    assign arg_vld  = vld_q;
    assign a        = a_q;
    assign b        = b_q;
    assign c        = c_q;
    assign credits  = cred_q;
    assign cred_err = err_q;

endmodule

// File: tb/tb_formula_arg_packer.sv
// tb_formula_arg_packer
//   Drives directed scenarios, then a randomized phase, into
//   formula_arg_packer. On every falling edge the bench compares all DUT
//   outputs against a word-count/credit model that the bench keeps itself.
//   Literal checks in the directed scenarios pin that model.
module tb_formula_arg_packer;

    localparam int CREDITS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_vld;
    logic [31:0] in_data;
    logic        in_rdy;
    logic        cred_ret;
    logic        arg_vld;
    logic [31:0] a, b, c;
    logic [7:0]  credits;
    logic        cred_err;

    int checks = 0;
    int errors = 0;

    formula_arg_packer #(.CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .cred_ret(cred_ret), .arg_vld(arg_vld),
        .a(a), .b(b), .c(c), .credits(credits), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_n counts the words already gathered for the current triple (0..2).
    int          m_n;
    int          m_cred;
    logic        m_err;
    logic        m_vld;
    logic [31:0] m_a, m_b, m_c;
    logic        m_rdy;
    logic        m_take;
    logic        m_issue;

    assign m_rdy   = !clr && (m_n < 2 || m_cred > 0);
    assign m_take  = in_vld && m_rdy;
    assign m_issue = m_take && m_n == 2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_cred <= CREDITS; m_err <= 1'b0; m_vld <= 1'b0;
            m_a <= '0; m_b <= '0; m_c <= '0;
        end else begin
            m_vld <= m_issue;
            if (clr) m_n <= 0;
            else if (m_take) begin
                if (m_n == 0) m_a <= in_data;
                if (m_n == 1) m_b <= in_data;
                if (m_n == 2) m_c <= in_data;
                m_n <= (m_n + 1) % 3;
            end
            if (m_issue && !cred_ret) m_cred <= m_cred - 1;
            else if (cred_ret && !m_issue) begin
                if (m_cred == CREDITS) m_err <= 1'b1;
                else m_cred <= m_cred + 1;
            end
        end
    end

    // Single compare process; inputs change only at posedge+2.
    always @(negedge clk) begin
        chk("in_rdy", 32'(in_rdy), 32'(m_rdy));
        chk("arg_vld", 32'(arg_vld), 32'(m_vld));
        chk("a", a, m_a);
        chk("b", b, m_b);
        chk("c", c, m_c);
        chk("credits", 32'(credits), 32'(m_cred));
        chk("cred_err", 32'(cred_err), 32'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic v, input logic [31:0] d, input logic r, input logic cl);
        in_vld = v; in_data = d; cred_ret = r; clr = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic word(input logic [31:0] d);
        drv(1'b1, d, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_arg_vld", 32'(arg_vld), 32'd0);
        chk("rst_a", a, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_pulse", 32'(arg_vld), 32'd0);

        // First triple: 16, 9, 4
        word(32'd16); word(32'd9); word(32'd4);
        chk("t1_vld", 32'(arg_vld), 32'd1);
        chk("t1_a", a, 32'd16);
        chk("t1_b", b, 32'd9);
        chk("t1_c", c, 32'd4);
        chk("t1_credits", 32'(credits), 32'd7);
        drv(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("t1_single_pulse", 32'(arg_vld), 32'd0);

        // Drain the remaining 7 credits with back-to-back triples.
        for (int i = 0; i < 7; i++) begin
            word(32'(i * 3)); word(32'(i * 3 + 1)); word(32'(i * 3 + 2));
        end
        chk("drain_credits", 32'(credits), 32'd0);
        word(32'd100); word(32'd101);
        drv(1'b1, 32'd102, 1'b0, 1'b0);
        #1 chk("stall_in_rdy", 32'(in_rdy), 32'd0);
        tick(); tick();
        chk("stall_no_pulse", 32'(arg_vld), 32'd0);
        drv(1'b1, 32'd102, 1'b1, 1'b0);
        tick();
        chk("ret_credit", 32'(credits), 32'd1);
        drv(1'b1, 32'd102, 1'b0, 1'b0);
        tick();
        chk("stall_issue", 32'(arg_vld), 32'd1);
        chk("stall_c", c, 32'd102);
        chk("stall_credits", 32'(credits), 32'd0);

        // Issue and return in the same cycle leave the count unchanged.
        drv(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) tick();
        word(32'd200); word(32'd201);
        drv(1'b1, 32'd202, 1'b1, 1'b0);
        tick();
        chk("same_cycle_credits", 32'(credits), 32'd3);
        chk("same_cycle_vld", 32'(arg_vld), 32'd1);

        // Overflow sets the sticky error.
        drv(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (5) tick();
        chk("full_credits", 32'(credits), 32'd8);
        chk("no_err_yet", 32'(cred_err), 32'd0);
        tick();
        chk("ovf_credits", 32'(credits), 32'd8);
        chk("ovf_err", 32'(cred_err), 32'd1);
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        drv(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (100) tick();
        chk("err_sticky", 32'(cred_err), 32'd1);

        // clr discards the partial triple.
        word(32'd1); word(32'd2);
        drv(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        word(32'd7); word(32'd8);
        chk("clr_no_early_pulse", 32'(arg_vld), 32'd0);
        word(32'd9);
        chk("clr_vld", 32'(arg_vld), 32'd1);
        chk("clr_a", a, 32'd7);
        chk("clr_b", b, 32'd8);
        chk("clr_c", c, 32'd9);

        // Asynchronous reset between edges, after the b word.
        word(32'd300); word(32'd301);
        drv(1'b0, 32'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("async_a", a, 32'd0);
        chk("async_b", b, 32'd0);
        chk("async_credits", 32'(credits), 32'd8);
        chk("async_err", 32'(cred_err), 32'd0);
        chk("async_in_rdy", 32'(in_rdy), 32'd1);
        tick();
        rst = 1'b0;
        word(32'd310); word(32'd311); word(32'd312);
        chk("rst_new_vld", 32'(arg_vld), 32'd1);
        chk("rst_new_a", a, 32'd310);
        chk("rst_new_c", c, 32'd312);
        chk("rst_new_credits", 32'(credits), 32'd7);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drv($urandom_range(0, 9) < 7, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 32) == 0);
            tick();
        end
        rst = 1'b0;
        drv(1'b0, 32'd0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
